// File: rtl/const_reverse_lookup_if.sv
// Request/result handshake bundle for the constant-table reverse lookup.
interface const_reverse_lookup_if;
    logic        in_valid;
    logic        in_ready;
    logic [28:0] in_value;
    logic        out_valid;
    logic        out_ready;
    logic        out_hit;
    logic [3:0]  out_index;
    logic [4:0]  out_count;

    modport slave (
        input  in_valid, in_value, out_ready,
        output in_ready, out_valid, out_hit, out_index, out_count
    );

    modport master (
        output in_valid, in_value, out_ready,
        input  in_ready, out_valid, out_hit, out_index, out_count
    );
endinterface

// File: rtl/const_reverse_lookup.sv
// Sequential reverse lookup over the 16-entry, 29-bit constant table:
// one entry per cycle, reports lowest matching index, hit flag and match count.
module const_reverse_lookup #(
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    const_reverse_lookup_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

    state_e      state_q, state_d;
    logic [28:0] val_q;
    logic [3:0]  idx_q;
    logic        hit_q;
    logic [3:0]  index_q;
    logic [4:0]  count_q;

    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;
    logic        out_hit_q, out_hit_d;
    logic [3:0]  out_index_q, out_index_d;
    logic [4:0]  out_count_q, out_count_d;

    logic match, accept, handoff, scan_end;

    // Literal values already truncated/zero-extended to 29 bits.
    function automatic logic [28:0] tbl(input logic [3:0] i);
        case (i)
            4'd0:    tbl = 29'd0;
            4'd1:    tbl = 29'd11;
            4'd2:    tbl = 29'd222;
            4'd3:    tbl = 29'd3456;
            4'd4:    tbl = 29'd146;
            4'd5:    tbl = 29'd1194684;
            4'd6:    tbl = 29'd342391;
            4'd7:    tbl = 29'd3456789;
            4'd8:    tbl = 29'd146;
            4'd9:    tbl = 29'd15036;
            4'd10:   tbl = 29'd14711;
            4'd11:   tbl = 29'd48917;
            4'd12:   tbl = 29'h0F626172;
            4'd13:   tbl = 29'h0F626172;
            4'd14:   tbl = 29'd1;
            default: tbl = 29'd15;
        endcase
    endfunction

    assign match    = (val_q == tbl(idx_q));
    assign accept   = (state_q == IDLE) && bus.in_valid && in_ready_q;
    assign handoff  = (state_q == DONE) && out_valid_q && bus.out_ready;
    assign scan_end = (idx_q == 4'd15) || (EARLY_EXIT && match);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_hit_q   <= 1'b0;
            out_index_q <= '0;
            out_count_q <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_hit_q   <= out_hit_d;
            out_index_q <= out_index_d;
            out_count_q <= out_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept)   state_d = SCAN;
            SCAN:    if (scan_end) state_d = DONE;
            DONE:    if (handoff)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Result registers load on DONE entry so a partial scan is never visible.
    always_comb begin
        in_ready_d  = (state_d == IDLE);
        out_valid_d = 1'b0;
        out_hit_d   = out_hit_q;
        out_index_d = out_index_q;
        out_count_d = out_count_q;
        if (state_q == DONE) begin
            if (!out_valid_q) begin
                out_valid_d = 1'b1;
                out_hit_d   = hit_q;
                out_index_d = index_q;
                out_count_d = count_q;
            end else if (bus.out_ready) begin
                out_hit_d   = 1'b0;
                out_index_d = '0;
                out_count_d = '0;
            end else begin
                out_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_q   <= '0;
            idx_q   <= '0;
            hit_q   <= 1'b0;
            index_q <= '0;
            count_q <= '0;
        end else if (accept) begin
            val_q   <= bus.in_value;
            idx_q   <= '0;
            hit_q   <= 1'b0;
            index_q <= '0;
            count_q <= '0;
        end else if (state_q == SCAN) begin
            if (match) begin
                count_q <= count_q + 5'd1;
                if (!hit_q) begin
                    hit_q   <= 1'b1;
                    index_q <= idx_q;
                end
            end
            if (!scan_end) idx_q <= idx_q + 4'd1;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_hit   = out_hit_q;
    assign bus.out_index = out_index_q;
    assign bus.out_count = out_count_q;
endmodule

// File: tb/tb_const_reverse_lookup.sv
// Scoreboard bench: dut0 scans fully, dut1 stops at the first match.
module tb_const_reverse_lookup;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    const_reverse_lookup_if if0();
    const_reverse_lookup_if if1();

    const_reverse_lookup #(.EARLY_EXIT(1'b0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    const_reverse_lookup #(.EARLY_EXIT(1'b1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    typedef struct {
        int hit;
        int idx;
        int cnt;
        int lat;
        int e0;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t cur[2];
    bit   seen[2];
    int   done_cnt[2];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic chk(input int w, input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL dut%0d %s: actual=%0d required=%0d (cycle %0d)", w, name, act, exp, cyc);
    endtask

    task automatic mon_step(input int w, input logic ov, input logic ordy, input logic irdy,
                            input logic hit, input logic [3:0] idx, input logic [4:0] cnt);
        if (ov) begin
            chk(w, "in_ready_low_while_valid", int'(irdy), 0);
            if (!seen[w]) begin
                seen[w] = 1'b1;
                if ((w == 0 ? q0.size() : q1.size()) == 0) begin
                    chk(w, "unexpected_out_valid", 1, 0);
                    cur[w] = '{hit: int'(hit), idx: int'(idx), cnt: int'(cnt), lat: 0, e0: 0};
                end else begin
                    cur[w] = (w == 0) ? q0.pop_front() : q1.pop_front();
                    chk(w, "latency", cyc - cur[w].e0, cur[w].lat);
                end
            end
            chk(w, "out_hit", int'(hit), cur[w].hit);
            chk(w, "out_index", int'(idx), cur[w].idx);
            chk(w, "out_count", int'(cnt), cur[w].cnt);
            if (ordy) begin
                seen[w] = 1'b0;
                done_cnt[w]++;
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen[0] = 1'b0;
                seen[1] = 1'b0;
            end else begin
                mon_step(0, if0.out_valid, if0.out_ready, if0.in_ready, if0.out_hit, if0.out_index, if0.out_count);
                mon_step(1, if1.out_valid, if1.out_ready, if1.in_ready, if1.out_hit, if1.out_index, if1.out_count);
            end
        end
    end

    task automatic drive(input int w, input logic v, input logic [28:0] val);
        if (w == 0) begin
            if0.in_valid = v;
            if0.in_value = val;
        end else begin
            if1.in_valid = v;
            if1.in_value = val;
        end
    endtask

    // Called #1 after a posedge; returns #1 after the accept edge.
    task automatic issue(input int w, input logic [28:0] val, input bit push,
                         input int hit, input int idx, input int cnt, input int lat);
        int   budget = 60;
        exp_t e;
        while (((w == 0) ? if0.in_ready : if1.in_ready) !== 1'b1 && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        if (budget == 0) chk(w, "in_ready_timeout", 0, 1);
        drive(w, 1'b1, val);
        @(posedge clk); #1;
        e = '{hit: hit, idx: idx, cnt: cnt, lat: lat, e0: cyc};
        if (push) begin
            if (w == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        drive(w, 1'b0, '0);
    endtask

    task automatic wait_done(input int w, input int target);
        int budget = 80;
        while (done_cnt[w] < target && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        if (budget == 0) chk(w, "result_timeout", done_cnt[w], target);
    endtask

    task automatic send(input int w, input logic [28:0] val,
                        input int hit, input int idx, input int cnt, input int lat);
        int target = done_cnt[w] + 1;
        issue(w, val, 1'b1, hit, idx, cnt, lat);
        wait_done(w, target);
    endtask

    task automatic chk_idle(input string tag);
        chk(0, {tag, "_in_ready"}, int'(if0.in_ready), 1);
        chk(0, {tag, "_out_valid"}, int'(if0.out_valid), 0);
        chk(0, {tag, "_out_hit"}, int'(if0.out_hit), 0);
        chk(0, {tag, "_out_index"}, int'(if0.out_index), 0);
        chk(0, {tag, "_out_count"}, int'(if0.out_count), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int target;
        int budget;
        drive(0, 1'b0, '0);
        drive(1, 1'b0, '0);
        if0.out_ready = 1'b1;
        if1.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_idle("in_reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_idle("after_reset");
        chk(1, "after_reset_in_ready", int'(if1.in_ready), 1);

        // Full scans: latency always 17
        send(0, 29'd3456, 1, 3, 1, 17);
        send(0, 29'd146, 1, 4, 2, 17);
        send(0, 29'h0F626172, 1, 12, 2, 17);
        send(0, 29'd15036, 1, 9, 1, 17);
        send(0, 29'd999, 0, 0, 0, 17);
        send(0, 29'd15, 1, 15, 1, 17);

        // Stalled result, then back-to-back request taken 1 cycle after handshake
        if0.out_ready = 1'b0;
        target = done_cnt[0] + 2;
        issue(0, 29'd1194684, 1'b1, 1, 5, 1, 17);
        budget = 40;
        while (if0.out_valid !== 1'b1 && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        if (budget == 0) chk(0, "stall_valid_timeout", 0, 1);
        drive(0, 1'b1, 29'd3456);
        repeat (5) begin
            @(posedge clk); #1;
        end
        chk(0, "stall_out_valid_held", int'(if0.out_valid), 1);
        if0.out_ready = 1'b1;
        @(posedge clk); #1;
        chk(0, "handshake_in_ready", int'(if0.in_ready), 1);
        chk(0, "handshake_out_valid", int'(if0.out_valid), 0);
        chk(0, "handshake_out_index", int'(if0.out_index), 0);
        @(posedge clk); #1;
        q0.push_back('{hit: 1, idx: 3, cnt: 1, lat: 17, e0: cyc});
        drive(0, 1'b0, '0);
        wait_done(0, target);

        // Early exit
        send(1, 29'd146, 1, 4, 1, 6);
        send(1, 29'd0, 1, 0, 1, 2);
        send(1, 29'd3456, 1, 3, 1, 5);
        send(1, 29'd999, 0, 0, 0, 17);
        send(1, 29'd15, 1, 15, 1, 17);

        // Reset mid-scan aborts with no result
        issue(0, 29'd3456, 1'b0, 0, 0, 0, 0);
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_idle("mid_scan_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (25) begin
            @(posedge clk); #1;
        end
        chk(0, "no_result_after_abort", int'(if0.out_valid), 0);
        send(0, 29'd11, 1, 1, 1, 17);

        chk(0, "scoreboard_empty", q0.size(), 0);
        chk(1, "scoreboard_empty", q1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/const_reverse_lookup.md
# const_reverse_lookup

Sequential reverse lookup for the 16-entry, 29-bit constant table driven by the 4-bit selector in the constant-literal test block. A 29-bit value is accepted over a valid/ready handshake. The block scans all table entries one per cycle and returns the lowest matching index, a hit flag and the number of matching entries. It sits downstream of the literal-encoding logic and confirms, in simulation and after synthesis, that truncation and sizing of each literal round-trip correctly.

## Interface
- EARLY_EXIT, 0: 1 = stop the scan at the first match; 0 = always scan all 16 entries.
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request
- in_value  in  29  value to look up
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_hit  out  1  at least one entry matched
- out_index  out  4  lowest matching index; 0 when there is no hit
- out_count  out  5  number of matching entries scanned (0..16)

## Operation
- Fixed table, index:value (decimal):
  - 0:0, 1:11, 2:222, 3:3456, 4:146, 5:1194684, 6:342391, 7:3456789
  - 8:146, 9:15036, 10:14711, 11:48917
  - 12:0x0F626172, 13:0x0F626172, 14:1, 15:15
- Table derivation rules:
  - Sized literals are truncated to their declared width and then zero-extended to 29 bits.
  - Strings are truncated to their low 29 bits.
  - Entry 15 is its own index (15).
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch in_value, clear idx, count, hit and index, then go to SCAN.
- SCAN, once per cycle:
  - Compare the latched value with table[idx].
  - On a match: count+=1; if hit==0, set hit=1 and index=idx.
  - Go to DONE when idx==15.
  - Go to DONE when EARLY_EXIT=1 and the current compare matches.
  - Otherwise idx+=1.
- DONE:
  - out_valid=1; out_hit, out_index and out_count are held stable.
  - On out_ready: go to IDLE.
- Comparison is an exact 29-bit unsigned equality; there is no sign extension.
- in_ready is 0 in SCAN and DONE, so new requests are back-pressured.
- count never exceeds 16; the 5-bit width covers this.

## Timing
- Reset (async assert, sync release):
  - State=IDLE.
  - in_ready=1, out_valid=0, out_hit=0, out_index=0, out_count=0.
  - Latched value and idx are cleared.
- Let the accept edge be E0. Entry k is compared in the cycle after edge E0+k.
- EARLY_EXIT=0: out_valid rises at edge E0+17, regardless of the value.
- EARLY_EXIT=1: out_valid rises at edge E0+k+2 for a first match at index k; with no match, at E0+17.
- out_valid stays high and the outputs stay frozen until out_ready is sampled high.
- out_valid and the result fields drop at the edge that samples out_ready.
- in_ready rises at that same edge, so the minimum gap between a result handshake and the next accept is 1 cycle.
- There is no same-cycle result-and-accept.
- out_ready high before out_valid has no effect.
- in_valid held during SCAN or DONE is ignored; it is taken only after the return to IDLE.
- Reset asserted mid-SCAN or in DONE aborts immediately. No partial result is ever presented.
- All outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- Reset, then idle: in_ready=1, out_valid=0, out_index=0, out_count=0, out_hit=0.
- EARLY_EXIT=0:
  - in_value=3456 -> out_valid at E0+17, hit=1, index=3, count=1.
  - in_value=146 -> hit=1, index=4, count=2 (duplicate at 8).
  - in_value=0x0F626172 -> index=12, count=2.
- EARLY_EXIT=0, in_value=1194684 with out_ready held low for 5 cycles after out_valid:
  - index=5, count=1, outputs stable throughout.
  - in_ready=0 until the handshake; a back-to-back request is accepted 1 cycle after it.
- EARLY_EXIT=0, misses: in_value=0x123ABC truncated case 16'h3ABC=15036 -> index=9.
  - in_value=999 -> hit=0, index=0, count=0.
  - in_value=15 -> index=15, count=1.
- EARLY_EXIT=1:
  - in_value=146 -> out_valid at E0+6, index=4, count=1.
  - in_value=0 -> out_valid at E0+2, index=0.
- rst_n pulsed low at E0+8 during a scan:
  - Outputs return to reset values asynchronously and no out_valid ever appears.
  - The next request (11) returns index=1.
